// File: rtl/pipe_fetch_reg.sv
// Fetch-side sequential stage: PC register and IF/ID pipeline register.
// Compensates for the synchronous instruction RAM with a one-entry hold buffer.
module pipe_fetch_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic [31:0] pc8_in,
    input  logic [31:0] ram_outdata,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] pc,
    output logic        ram_ena,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic        id_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc8;
    logic        r_valid;
    logic        r_held;
    logic [31:0] r_hold;

    logic [31:0] w_live;

    // PC and IF/ID registers: flush beats stall beats advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_id_pc  <= 32'h0;
            r_id_pc8 <= 32'h0;
            r_valid  <= 1'b0;
        end else if (flush) begin
            r_pc     <= npc;
            r_id_pc  <= r_pc;
            r_id_pc8 <= pc8_in;
            r_valid  <= 1'b0;
        end else if (!stall) begin
            r_pc     <= npc;
            r_id_pc  <= r_pc;
            r_id_pc8 <= pc8_in;
            r_valid  <= 1'b1;
        end
    end

    // Hold buffer: first stalled edge captures the word in ID, later stalls replay it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held <= 1'b0;
            r_hold <= 32'h0;
        end else if (flush) begin
            r_held <= 1'b0;
        end else if (stall) begin
            if (!r_held) begin
                r_hold <= ram_outdata;
                r_held <= 1'b1;
            end
        end else begin
            r_held <= 1'b0;
        end
    end

    // RAM re-reads pc during a stall, so the held copy overrides it
    always_comb begin
        w_live  = r_held ? r_hold : ram_outdata;
        id_inst = r_valid ? w_live : NOP;
    end

    assign ram_ena  = ~rst;
    assign pc       = r_pc;
    assign id_pc    = r_id_pc;
    assign id_pc8   = r_id_pc8;
    assign id_valid = r_valid;

endmodule

// File: tb/tb_pipe_fetch_reg.sv
// Bench for pipe_fetch_reg: synchronous RAM model, in-order reference model,
// scoreboard queue drained by an independent monitor.
module tb_pipe_fetch_reg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc;
    logic [31:0] pc8_in;
    logic [31:0] ram_q;
    logic        stall;
    logic        flush;
    logic [31:0] pc;
    logic        ram_ena;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic        id_valid;

    pipe_fetch_reg #(
        .RESET_PC(RESET_PC),
        .NOP     (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .npc        (npc),
        .pc8_in     (pc8_in),
        .ram_outdata(ram_q),
        .stall      (stall),
        .flush      (flush),
        .pc         (pc),
        .ram_ena    (ram_ena),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_pc8     (id_pc8),
        .id_valid   (id_valid)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];

    initial begin
        ram_q = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    end

    // Synchronous instruction RAM: word appears one clock after the address
    always @(posedge clk) begin
        if (ram_ena) ram_q <= mem[pc[9:2]];
    end

    typedef struct {
        logic [31:0] pc;
        logic        v;
        logic [31:0] ipc;
        logic [31:0] ipc8;
        logic [31:0] inst;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: fetch PC plus the instruction currently in decode
    logic [31:0] m_pc;
    logic        m_v;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc8;
    logic [31:0] m_inst;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = RESET_PC;
        m_v    = 1'b0;
        m_ipc  = 32'h0;
        m_ipc8 = 32'h0;
        m_inst = NOP;
    endtask

    // Drive one cycle at the falling edge and push what ID must show after it
    task automatic step(input logic s, input logic f,
                        input logic use_tgt, input logic [31:0] tgt);
        logic [31:0] n;
        exp_t        e;
        n      = use_tgt ? tgt : m_pc + 32'd4;
        stall  = s;
        flush  = f;
        pc8_in = m_pc + 32'd8;
        npc    = (s && !f) ? $urandom : n;
        if (f) begin
            m_v    = 1'b0;
            m_inst = NOP;
            m_pc   = n;
        end else if (!s) begin
            m_v    = 1'b1;
            m_ipc  = m_pc;
            m_ipc8 = m_pc + 32'd8;
            m_inst = mem[m_pc[9:2]];
            m_pc   = n;
        end
        e.pc   = m_pc;
        e.v    = m_v;
        e.ipc  = m_ipc;
        e.ipc8 = m_ipc8;
        e.inst = m_inst;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: after every rising edge, compare against the oldest expectation
    always begin
        @(posedge clk);
        #1;
        if (!rst && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc", pc, e.pc);
            chk("ram_ena", {31'h0, ram_ena}, 32'h1);
            chk("id_valid", {31'h0, id_valid}, {31'h0, e.v});
            chk("id_inst", id_inst, e.inst);
            if (e.v) begin
                chk("id_pc", id_pc, e.ipc);
                chk("id_pc8", id_pc8, e.ipc8);
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, pc, RESET_PC);
        chk({tag, "_valid"}, {31'h0, id_valid}, 32'h0);
        chk({tag, "_inst"}, id_inst, NOP);
        chk({tag, "_idpc"}, id_pc, 32'h0);
        chk({tag, "_idpc8"}, id_pc8, 32'h0);
        chk({tag, "_ramena"}, {31'h0, ram_ena}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        stall  = 1'b0;
        flush  = 1'b0;
        npc    = 32'h0;
        pc8_in = 32'h0;
        #1;
        chk_reset("rst0");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();

        // sequential fetch, 3-cycle stall at id_pc = 8, release
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
        // flush to 0x40, then fetch from target
        step(1'b0, 1'b1, 1'b1, 32'h0000_0040);
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
        // stall with held set, then flush and stall together
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
        // 1-0-1 stall patterns
        repeat (3) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            step(1'b0, 1'b0, 1'b0, 32'h0);
        end
        // stall during a bubble
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);

        // asynchronous reset in the middle of a stall with held set
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic s;
            logic f;
            logic t;
            s = ($urandom_range(0, 99) < 30);
            f = ($urandom_range(0, 99) < 10);
            t = ($urandom_range(0, 99) < 15);
            step(s, f, t, {22'h0, 8'($urandom_range(0, 255)), 2'b00});
        end

        stall = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_fetch_reg.md
# pipe_fetch_reg

Fetch-side sequential stage of the 5-stage MIPS pipeline. It owns the program-counter register that drives the instruction-fetch stage and the IF/ID pipeline register that feeds decode. It compensates for the synchronous instruction RAM, whose output appears one clock after the address. Stall support uses a one-entry hold buffer, and flush support injects NOP bubbles when decode redirects control flow.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP, 32'h0000_0000, instruction word presented to ID for bubbles (sll $0,$0,0)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- npc  in  32  next PC selected by the fetch stage (pc+4 / jr / branch / jump)
- pc8_in  in  32  pc+8 computed by the fetch stage for the current pc
- ram_outdata  in  32  instruction RAM output; word at the address sampled on the previous edge
- stall  in  1  ID hazard stall; freeze PC and IF/ID
- flush  in  1  taken redirect; squash the instruction entering ID
- pc  out  32  current fetch PC, to fetch stage and RAM address
- ram_ena  out  1  instruction RAM enable
- id_inst  out  32  instruction presented to decode
- id_pc  out  32  PC of id_inst
- id_pc8  out  32  pc+8 of id_inst, for jal/bal link
- id_valid  out  1  id_inst is a real instruction, not a bubble

## Operation
- Registers: pc_q, id_pc_q, id_pc8_q, valid_q, held_q, hold_q[31:0].
- ram_enable: ram_ena = ~rst. The RAM reads every cycle. Correctness does not depend on the RAM holding its output.
- Instruction select: id_inst = !valid_q ? NOP : (held_q ? hold_q : ram_outdata).
- Edge priority, evaluated at each rising edge, highest priority first:
  1. flush = 1 (whether or not stall is also asserted):
     - pc_q <= npc
     - valid_q <= 0
     - held_q <= 0
     - id_pc_q and id_pc8_q are don't-care and must not be X-propagating; load pc and pc8_in
  2. stall = 1:
     - pc_q, id_pc_q, id_pc8_q and valid_q hold
     - if held_q = 0: hold_q <= ram_outdata, held_q <= 1
     - if held_q = 1: hold_q holds
  3. otherwise (advance):
     - pc_q <= npc
     - id_pc_q <= pc_q
     - id_pc8_q <= pc8_in
     - valid_q <= 1
     - held_q <= 0
- The hold buffer exists because the RAM re-reads pc_q during a stall. Its output then becomes the word at pc_q, not the word in ID. The first stalled cycle captures the correct word, and subsequent stalled cycles replay it.
- Releasing a stall needs no replay. At the release edge the RAM samples pc_q, and that word becomes the new ID instruction in the same edge as id_pc_q <= pc_q.
- A stall while valid_q = 0 holds the bubble. id_inst stays NOP, and the hold buffer may capture but is masked.

## Timing
- Reset values, applied asynchronously while rst = 1:
  - pc = RESET_PC
  - id_pc = 0, id_pc8 = 0
  - valid = 0, held = 0, hold = 0
  - id_inst = NOP
  - ram_ena = 0
- First edge after rst falls: the RAM samples RESET_PC and pc becomes npc. id_valid = 1, id_pc = RESET_PC, and id_inst = mem[RESET_PC].
- Latency: an instruction fetched at pc on edge n is visible in ID for the cycle after edge n, i.e. one cycle.
- Throughput: one instruction per cycle when stall = flush = 0.
- Flush: exactly one bubble per flush-asserted edge. The redirect target is fetched on the next edge and valid in ID one cycle later.
- Stall of length k: ID contents are unchanged for k cycles. pc holds for k edges.
- Reset mid-stall or mid-flush: all state returns to reset values immediately, and the hold buffer is discarded.
- No combinational path from stall or flush to any output. Outputs are registered, except id_inst, which is a mux of registers and the RAM output register.

## Test plan
- Reset and sequential fetch: RESET_PC = 0, npc = pc+4, RAM holds mem[i] = 32'h1000_0000+i. The first three post-reset cycles must give id_pc = 0/4/8, id_inst = 32'h1000_0000/…01/…02, id_pc8 = 8/12/16, and id_valid = 1.
- Three-cycle stall with id_pc = 8: id_inst must stay 32'h1000_0002 for all three cycles while pc stays 12. After release, id_pc = 12 with id_inst = …03. No instruction may be skipped or duplicated.
- Flush with npc = 32'h0000_0040: the next cycle must show id_valid = 0 and id_inst = NOP. The cycle after must show id_pc = 0x40 with id_inst = mem[16].
- Flush and stall in the same cycle: flush wins. pc must become npc and ID must show a bubble, with held cleared.
- Asynchronous reset asserted mid-stall, with held = 1: pc must read RESET_PC, id_valid must be 0 and id_inst must be NOP before the next clock edge. Fetch must restart from RESET_PC after release.
- Back-to-back stall, release, stall (1-0-1 pattern): the ID sequence must match a golden in-order instruction stream with no replayed stale hold data.
